// File: rtl/usb4_clk_en_reset_seq.sv
// Clock-enable and reset sequencer for the USB4 logical layer: per-generation lane
// strobe, sideband tick, SB-timed core reset and glitch-free generation switching.
module usb4_clk_en_reset_seq #(
  parameter int unsigned DIV_W         = 5,
  parameter int unsigned DIV_GEN2      = 8,
  parameter int unsigned DIV_GEN3      = 4,
  parameter int unsigned DIV_GEN4      = 2,
  parameter int unsigned SB_DIV_W      = 17,
  parameter int unsigned SB_DIV        = 80000,
  parameter int unsigned RST_SB_CYCLES = 3,
  parameter int unsigned QUIET_CYCLES  = 4,
  parameter logic [1:0]  GEN_RESET     = 2'd2
) (
  input  logic       local_clk,
  input  logic       rst,
  input  logic       gen_req,
  input  logic [1:0] gen_sel,
  output logic       gen_req_ready,
  output logic       gen_err,
  output logic [1:0] gen_active,
  output logic       lane_clk_en,
  output logic       sb_clk_en,
  output logic       core_rst_n,
  output logic       busy
);

  localparam int unsigned HOLD_W  = (RST_SB_CYCLES > 1) ? $clog2(RST_SB_CYCLES) : 1;
  localparam int unsigned QUIET_W = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_WAIT_EDGE, S_DRAIN} state_t;

  state_t              state, state_nxt;
  logic [SB_DIV_W-1:0] sb_cnt;
  logic [DIV_W-1:0]    lane_cnt;
  logic [DIV_W-1:0]    lane_div;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [QUIET_W-1:0]  quiet_cnt;
  logic [1:0]          pending;
  logic                sb_tick, lane_last, quiet_last, hold_last;
  logic                accept, sel_legal;

  always_comb begin
    case (gen_active)
      2'd0:    lane_div = DIV_W'(DIV_GEN2);
      2'd1:    lane_div = DIV_W'(DIV_GEN3);
      default: lane_div = DIV_W'(DIV_GEN4);
    endcase
  end

  assign sb_tick    = (sb_cnt == SB_DIV_W'(SB_DIV - 1));
  assign lane_last  = (lane_cnt == lane_div - DIV_W'(1));
  assign quiet_last = (quiet_cnt == QUIET_W'(QUIET_CYCLES - 1));
  assign hold_last  = (hold_cnt == HOLD_W'(RST_SB_CYCLES - 1));
  assign accept     = gen_req && gen_req_ready;
  assign sel_legal  = (gen_sel != 2'd3);

  always_ff @(posedge local_clk) begin
    if (!rst) state <= S_HOLD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD:      if (sb_tick && hold_last) state_nxt = S_RUN;
      S_RUN:       if (accept && sel_legal && gen_sel != gen_active) state_nxt = S_WAIT_EDGE;
      S_WAIT_EDGE: if (lane_last) state_nxt = S_DRAIN;
      S_DRAIN:     if (quiet_last) state_nxt = S_RUN;
      default:     state_nxt = S_HOLD;
    endcase
  end

  always_comb begin
    gen_req_ready = (state == S_HOLD) || (state == S_RUN);
    busy          = (state != S_RUN);
    core_rst_n    = (state != S_HOLD);
    sb_clk_en     = sb_tick;
    // WAIT_EDGE keeps the old divider so the final strobe is a full period
    lane_clk_en   = ((state == S_RUN) || (state == S_WAIT_EDGE)) && lane_last;
  end

  always_ff @(posedge local_clk) begin
    if (!rst) begin
      sb_cnt     <= '0;
      lane_cnt   <= '0;
      hold_cnt   <= '0;
      quiet_cnt  <= '0;
      gen_active <= GEN_RESET;
      pending    <= GEN_RESET;
      gen_err    <= 1'b0;
    end else begin
      sb_cnt  <= sb_tick ? '0 : sb_cnt + 1'b1;
      gen_err <= accept && !sel_legal;
      case (state)
        S_HOLD: begin
          lane_cnt <= '0;
          if (sb_tick) hold_cnt <= hold_cnt + 1'b1;
          if (accept && sel_legal) gen_active <= gen_sel;
        end
        S_RUN, S_WAIT_EDGE: begin
          lane_cnt  <= lane_last ? '0 : lane_cnt + 1'b1;
          quiet_cnt <= '0;
          if (state == S_RUN && accept && sel_legal) pending <= gen_sel;
        end
        S_DRAIN: begin
          lane_cnt  <= '0;
          quiet_cnt <= quiet_cnt + 1'b1;
          if (quiet_last) gen_active <= pending;
        end
        default: lane_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_usb4_clk_en_reset_seq.sv
// Bench for usb4_clk_en_reset_seq: an event-time model (cycles since release, strobe
// epochs, switch windows) checked every cycle, plus hand-computed literal checkpoints.
module tb_usb4_clk_en_reset_seq;

  localparam int SB    = 10;
  localparam int RSTC  = 3;
  localparam int QUIET = 4;
  localparam int REL   = SB * RSTC;
  localparam logic [1:0] GRST = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       gen_req = 1'b0;
  logic [1:0] gen_sel = 2'd0;
  logic       gen_req_ready, gen_err, lane_clk_en, sb_clk_en, core_rst_n, busy;
  logic [1:0] gen_active;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  usb4_clk_en_reset_seq #(
    .DIV_W(5), .DIV_GEN2(8), .DIV_GEN3(4), .DIV_GEN4(2),
    .SB_DIV_W(17), .SB_DIV(SB), .RST_SB_CYCLES(RSTC),
    .QUIET_CYCLES(QUIET), .GEN_RESET(GRST)
  ) dut (
    .local_clk(clk), .rst(rst), .gen_req(gen_req), .gen_sel(gen_sel),
    .gen_req_ready(gen_req_ready), .gen_err(gen_err), .gen_active(gen_active),
    .lane_clk_en(lane_clk_en), .sb_clk_en(sb_clk_en), .core_rst_n(core_rst_n),
    .busy(busy)
  );

  // Model: m_k = cycles since reset release; strobes fall at run_start + n*D + D-1.
  // A switch accepted at k ends the old epoch at the next strobe s > k; the new epoch
  // starts at s + QUIET + 1.
  int         m_k = 0;
  int         m_run_start = REL;
  int         m_s = 0;
  int         m_d, m_ph;
  logic [1:0] m_gen = GRST;
  logic [1:0] m_new = GRST;
  bit         m_sw = 1'b0;
  bit         m_err = 1'b0;
  bit         m_valid = 1'b0;
  bit         m_hold, m_rdy;

  function automatic int div_of(input logic [1:0] g);
    case (g)
      2'd0:    return 8;
      2'd1:    return 4;
      default: return 2;
    endcase
  endfunction

  function automatic bit strobe_at(input int k);
    int d;
    if (k < REL) return 1'b0;
    if (m_sw && k > m_s) return 1'b0;
    d = div_of(m_gen);
    return ((k - m_run_start) % d) == d - 1;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_k = 0; m_gen = GRST; m_sw = 1'b0; m_run_start = REL; m_err = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_hold = (m_k < REL);
      m_rdy  = m_hold || !m_sw;
      m_err  = 1'b0;
      if (gen_req && m_rdy) begin
        if (gen_sel == 2'd3) m_err = 1'b1;
        else if (m_hold) m_gen = gen_sel;
        else if (gen_sel != m_gen) begin
          m_d   = div_of(m_gen);
          m_ph  = (m_k - m_run_start) % m_d;
          m_sw  = 1'b1;
          m_new = gen_sel;
          m_s   = (m_ph == m_d - 1) ? m_k + m_d : m_k + (m_d - 1 - m_ph);
        end
      end
      m_k++;
      if (m_sw && m_k == m_s + QUIET + 1) begin
        m_gen = m_new; m_run_start = m_k; m_sw = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d actual=%0d required=%0d", name, m_k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("sb_clk_en",     {1'b0, sb_clk_en},     {1'b0, (m_k % SB) == SB - 1});
      check("core_rst_n",    {1'b0, core_rst_n},    {1'b0, m_k >= REL});
      check("gen_req_ready", {1'b0, gen_req_ready}, {1'b0, (m_k < REL) || !m_sw});
      check("busy",          {1'b0, busy},          {1'b0, (m_k < REL) || m_sw});
      check("gen_active",    gen_active,            m_gen);
      check("gen_err",       {1'b0, gen_err},       {1'b0, m_err});
      check("lane_clk_en",   {1'b0, lane_clk_en},   {1'b0, strobe_at(m_k)});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_k(input int t);
    for (int i = 0; i < 200 && m_k != t; i++) step(1);
    n_assert++;
    if (m_k != t) begin
      n_fail++;
      $display("FAIL at_k actual=%0d required=%0d", m_k, t);
    end
  endtask

  task automatic lit_reset(input string tag);
    check({tag, "_core_rst_n"}, {1'b0, core_rst_n},    2'd0);
    check({tag, "_gen_active"}, gen_active,            GRST);
    check({tag, "_busy"},       {1'b0, busy},          2'd1);
    check({tag, "_ready"},      {1'b0, gen_req_ready}, 2'd1);
    check({tag, "_lane"},       {1'b0, lane_clk_en},   2'd0);
    check({tag, "_sb"},         {1'b0, sb_clk_en},     2'd0);
    check({tag, "_err"},        {1'b0, gen_err},       2'd0);
  endtask

  initial begin
    rst = 1'b0;
    step(2);
    lit_reset("rst1");
    rst = 1'b1;
    at_k(9);  check("sb_first", {1'b0, sb_clk_en}, 2'd1); check("core_hold", {1'b0, core_rst_n}, 2'd0);
    at_k(10); check("sb_off", {1'b0, sb_clk_en}, 2'd0);
    at_k(29); check("sb_third", {1'b0, sb_clk_en}, 2'd1); check("core_last_hold", {1'b0, core_rst_n}, 2'd0);
    at_k(30); check("core_rel", {1'b0, core_rst_n}, 2'd1); check("busy_run", {1'b0, busy}, 2'd0);
    check("lane_first0", {1'b0, lane_clk_en}, 2'd0);
    at_k(31); check("g4_strobe", {1'b0, lane_clk_en}, 2'd1);
    at_k(32); check("g4_gap", {1'b0, lane_clk_en}, 2'd0);
    gen_req = 1'b1; gen_sel = 2'd0;
    at_k(33); check("sw_last_strobe", {1'b0, lane_clk_en}, 2'd1); check("sw_ready0", {1'b0, gen_req_ready}, 2'd0);
    check("sw_gen_old", gen_active, 2'd2);
    gen_req = 1'b0;
    at_k(34); check("drain_quiet", {1'b0, lane_clk_en}, 2'd0);
    at_k(37); check("drain_end_gen", gen_active, 2'd2);
    at_k(38); check("run_gen2", gen_active, 2'd0); check("run_ready", {1'b0, gen_req_ready}, 2'd1);
    at_k(45); check("g2_strobe", {1'b0, lane_clk_en}, 2'd1);
    at_k(46); gen_req = 1'b1; gen_sel = 2'd3;
    at_k(47); check("err_pulse", {1'b0, gen_err}, 2'd1); check("err_gen", gen_active, 2'd0);
    gen_req = 1'b0;
    at_k(48); check("err_clear", {1'b0, gen_err}, 2'd0);
    gen_req = 1'b1; gen_sel = 2'd1;
    at_k(49); check("wait_ready0", {1'b0, gen_req_ready}, 2'd0);
    gen_sel = 2'd2;
    at_k(53); check("g2_last_strobe", {1'b0, lane_clk_en}, 2'd1);
    at_k(57); check("drop_gen", gen_active, 2'd0); check("drop_ready", {1'b0, gen_req_ready}, 2'd0);
    at_k(58); check("run_gen3", gen_active, 2'd1); check("held_ready", {1'b0, gen_req_ready}, 2'd1);
    at_k(59); check("held_taken", {1'b0, gen_req_ready}, 2'd0);
    gen_req = 1'b0;
    at_k(61); check("g3_last_strobe", {1'b0, lane_clk_en}, 2'd1);
    at_k(66); check("run_gen4", gen_active, 2'd2);
    at_k(67); check("g4_strobe2", {1'b0, lane_clk_en}, 2'd1);
    gen_req = 1'b1; gen_sel = 2'd0;
    at_k(68); gen_req = 1'b0;
    at_k(71); check("drain2_busy", {1'b0, busy}, 2'd1); check("drain2_lane", {1'b0, lane_clk_en}, 2'd0);
    rst = 1'b0;
    step(1);
    lit_reset("rst2");
    rst = 1'b1;
    at_k(5); gen_req = 1'b1; gen_sel = 2'd1;
    at_k(6); check("hold_gen", gen_active, 2'd1); check("hold_busy", {1'b0, busy}, 2'd1);
    gen_req = 1'b0;
    at_k(29); check("rehold_core", {1'b0, core_rst_n}, 2'd0);
    at_k(30); check("rehold_rel", {1'b0, core_rst_n}, 2'd1);
    at_k(33); check("g3_first", {1'b0, lane_clk_en}, 2'd1);
    at_k(34); check("g3_gap", {1'b0, lane_clk_en}, 2'd0);
    at_k(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
